// File: rtl/rv_if_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack port into a
// small prefetch FIFO and presents the head entry to decode; handles stall and redirect.
module rv_if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    input  logic        JUMP_EN,
    input  logic [31:0] JUMP_ADDR,
    input  logic        HOLD_EN,
    output logic [31:0] IF2ID_ADDR,
    output logic [31:0] IF2ID_INS,
    output logic        IF2ID_VALID,
    output logic        WASH_EN
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic               wash_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        fifo_addr_q [FIFO_DEPTH];
    logic [31:0]        fifo_ins_q  [FIFO_DEPTH];

    logic               req_s;
    logic [31:0]        addr_s;
    logic               push_s;
    logic               pop_s;
    logic               not_empty_s;
    logic [31:0]        jump_tgt_s;

    assign not_empty_s = (count_q != {CNT_W{1'b0}});
    assign pop_s       = not_empty_s & ~HOLD_EN & ~JUMP_EN;
    assign jump_tgt_s  = JUMP_ADDR & 32'hFFFF_FFFC;

    // Fetch FSM next state, request generation and PC update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        req_s      = 1'b0;
        addr_s     = pc_q;
        push_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_s  = (count_q < CNT_W'(FIFO_DEPTH)) & ~JUMP_EN;
                addr_s = pc_q;
                if (req_s) begin
                    req_addr_d = pc_q;
                    if (IMEM_ACK) begin
                        push_s = 1'b1;
                        pc_d   = pc_q + 32'd4;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    req_addr_d = req_addr_q;
                end
            end
            ST_WAIT: begin
                req_s  = 1'b1;
                addr_s = req_addr_q;
                if (IMEM_ACK && !JUMP_EN) begin
                    push_s  = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_IDLE;
                end else if (IMEM_ACK) begin
                    state_d = ST_IDLE;
                end else if (JUMP_EN) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                // Stale request must still complete at its original address.
                req_s  = 1'b1;
                addr_s = req_addr_q;
                if (IMEM_ACK) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (JUMP_EN) begin
            pc_d = jump_tgt_s;
        end else begin
            pc_d = pc_d;
        end
    end

    // FSM, PC and wash pulse registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_ADDR;
            req_addr_q <= RESET_ADDR;
            wash_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            wash_q     <= JUMP_EN;
        end
    end

    // Prefetch FIFO storage, pointers and occupancy; a redirect empties it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= 32'h0000_0000;
                fifo_ins_q[i]  <= 32'h0000_0000;
            end
        end else if (JUMP_EN) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_addr_q[wr_ptr_q] <= pc_q;
                fifo_ins_q[wr_ptr_q]  <= IMEM_RDATA;
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Decode-side presentation of the FIFO head, NOP filler when empty.
    always_comb begin
        if (not_empty_s) begin
            IF2ID_ADDR = fifo_addr_q[rd_ptr_q];
            IF2ID_INS  = fifo_ins_q[rd_ptr_q];
        end else begin
            IF2ID_ADDR = 32'h0000_0000;
            IF2ID_INS  = NOP_INS;
        end
    end

    assign IF2ID_VALID = not_empty_s;
    assign IMEM_REQ    = req_s & nRST;
    assign IMEM_ADDR   = addr_s;
    assign WASH_EN     = wash_q;

endmodule

// File: tb/tb_rv_if_fetch.sv
// Self-checking bench for rv_if_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level model of the fetch stage.
module tb_rv_if_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK;
    logic        nRST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        JUMP_EN;
    logic [31:0] JUMP_ADDR;
    logic        HOLD_EN;
    logic [31:0] IF2ID_ADDR;
    logic [31:0] IF2ID_INS;
    logic        IF2ID_VALID;
    logic        WASH_EN;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [31:0] m_pc;
    logic [31:0] m_oaddr;
    logic        m_out;
    logic        m_disc;
    logic        m_wash;
    logic [63:0] m_q[$];
    int          wait_cnt;
    int          lat;

    rv_if_fetch #(
        .RESET_ADDR (RADDR),
        .FIFO_DEPTH (DEPTH),
        .NOP_INS    (NOP)
    ) u_dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .JUMP_EN     (JUMP_EN),
        .JUMP_ADDR   (JUMP_ADDR),
        .HOLD_EN     (HOLD_EN),
        .IF2ID_ADDR  (IF2ID_ADDR),
        .IF2ID_INS   (IF2ID_INS),
        .IF2ID_VALID (IF2ID_VALID),
        .WASH_EN     (WASH_EN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_pc     = RADDR;
        m_oaddr  = RADDR;
        m_out    = 1'b0;
        m_disc   = 1'b0;
        m_wash   = 1'b0;
        wait_cnt = 0;
        m_q.delete();
    endtask

    // mode: 0 zero-wait, 1 fixed latency, 2 random, 3 never ack, 4 ack always
    task automatic step(input logic rst_n_v, input logic hold_v, input logic jump_v,
                        input logic [31:0] jaddr_v, input int mode);
        logic        e_req;
        logic [31:0] e_addr;
        logic        ack;
        logic [31:0] rdata;
        logic        e_valid;
        logic [31:0] e_ifa;
        logic [31:0] e_ins;
        logic        completed;
        @(negedge CLK);
        nRST      = rst_n_v;
        HOLD_EN   = hold_v;
        JUMP_EN   = jump_v;
        JUMP_ADDR = jaddr_v;
        e_addr = m_pc;
        if (!rst_n_v) begin
            e_req = 1'b0;
        end else if (m_out) begin
            e_req  = 1'b1;
            e_addr = m_oaddr;
        end else begin
            e_req = (m_q.size() < DEPTH) && !jump_v;
        end
        case (mode)
            0:       ack = e_req;
            1:       ack = e_req && (wait_cnt >= lat);
            2:       ack = e_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            3:       ack = 1'b0;
            default: ack = 1'b1;
        endcase
        rdata      = e_req ? mem_word(e_addr) : $urandom;
        IMEM_ACK   = ack;
        IMEM_RDATA = rdata;
        e_valid = (m_q.size() != 0);
        e_ifa   = e_valid ? m_q[0][63:32] : 32'h0000_0000;
        e_ins   = e_valid ? m_q[0][31:0]  : NOP;
        #1;
        check_val("imem_req", 32'(IMEM_REQ), 32'(e_req));
        if (e_req) check_val("imem_addr", IMEM_ADDR, e_addr);
        check_val("if2id_valid", 32'(IF2ID_VALID), 32'(e_valid));
        check_val("if2id_addr", IF2ID_ADDR, e_ifa);
        check_val("if2id_ins", IF2ID_INS, e_ins);
        check_val("wash_en", 32'(WASH_EN), 32'(m_wash));
        // advance model to the next edge
        if (!rst_n_v) begin
            model_reset();
        end else begin
            completed = e_req && ack;
            if (m_q.size() != 0 && !hold_v && !jump_v) void'(m_q.pop_front());
            if (completed && !m_disc && !jump_v) begin
                m_q.push_back({e_addr, rdata});
                m_pc = e_addr + 32'd4;
            end
            if (completed) begin
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (e_req) begin
                m_out   = 1'b1;
                m_oaddr = e_addr;
            end
            if (jump_v) begin
                m_q.delete();
                m_pc = jaddr_v & ~32'd3;
                if (m_out) m_disc = 1'b1;
            end
            m_wash = jump_v;
            if (e_req && !ack) wait_cnt++;
            else wait_cnt = 0;
        end
    endtask

    initial begin
        int mode;
        nRST = 1'b0; HOLD_EN = 1'b0; JUMP_EN = 1'b0; JUMP_ADDR = 32'h0;
        IMEM_ACK = 1'b0; IMEM_RDATA = 32'h0; lat = 0;
        repeat (2) @(posedge CLK);
        model_reset();

        // reset state
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        check_val("rst_req", 32'(IMEM_REQ), 32'h0);
        check_val("rst_valid", 32'(IF2ID_VALID), 32'h0);
        check_val("rst_ins", IF2ID_INS, NOP);
        check_val("rst_addr", IF2ID_ADDR, 32'h0);
        check_val("rst_wash", 32'(WASH_EN), 32'h0);

        // zero-wait stream across the address wrap
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        check_val("zw_a0", IMEM_ADDR, 32'hFFFF_FFF8);
        check_val("zw_v0", 32'(IF2ID_VALID), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        check_val("zw_a1", IMEM_ADDR, 32'hFFFF_FFFC);
        check_val("zw_if1", IF2ID_ADDR, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        check_val("zw_a2", IMEM_ADDR, 32'h0000_0000);
        check_val("zw_if2", IF2ID_ADDR, 32'hFFFF_FFFC);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 0);

        // stall fills the FIFO and stops requests
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0, 0);
        check_val("hold_req", 32'(IMEM_REQ), 32'h0);
        check_val("hold_valid", 32'(IF2ID_VALID), 32'h1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0, 0);

        // redirect while waiting on a 3-cycle memory
        lat = 3;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        check_val("drop_wash", 32'(WASH_EN), 32'h1);
        check_val("drop_addr", IMEM_ADDR, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        check_val("drop_wash_end", 32'(WASH_EN), 32'h0);
        check_val("drop_stale", 32'(IF2ID_VALID), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        check_val("drop_new_addr", IMEM_ADDR, 32'h0000_0100);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1);

        // redirect coincident with ack in WAIT
        step(1'b0, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0202, 4);
        step(1'b1, 1'b0, 1'b0, 32'h0, 3);
        check_val("jack_valid", 32'(IF2ID_VALID), 32'h0);
        check_val("jack_ins", IF2ID_INS, NOP);
        check_val("jack_addr", IMEM_ADDR, 32'h0000_0200);
        check_val("jack_wash", 32'(WASH_EN), 32'h1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 0);

        // reset while waiting, stray ack during reset
        step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        step(1'b1, 1'b1, 1'b0, 32'h0, 3);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4);
        check_val("rw_req", 32'(IMEM_REQ), 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4);
        check_val("rw_valid", 32'(IF2ID_VALID), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 0);
        check_val("rw_first", IMEM_ADDR, RADDR);

        // randomized traffic
        for (int chunk = 0; chunk < 16; chunk++) begin
            mode = $urandom_range(0, 2);
            lat  = $urandom_range(0, 3);
            for (int c = 0; c < 40; c++) begin
                step(($urandom_range(0, 63) != 0),
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 11) == 0),
                     (($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom),
                     mode);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_if_fetch.md
Name: rv_if_fetch

Overview:
- Instruction fetch stage: owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small prefetch FIFO and drives the IF2ID_ADDR / IF2ID_INS pair consumed by the decode stage.
- Handles stall (HOLD_EN) and redirect (JUMP_EN). On redirect it generates the one-cycle WASH_EN pipeline flush.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; legal values 2 and 4.
- NOP_INS, 32'h0000_0013, instruction driven when no valid entry (ADDI x0,x0,0).

Ports:
- CLK  in  1  rising-edge clock
- nRST  in  1  reset; synchronous, active-low
- IMEM_REQ  out  1  fetch request; held high until acknowledged
- IMEM_ADDR  out  32  word-aligned fetch address; stable while IMEM_REQ=1
- IMEM_ACK  in  1  memory accepts request and returns data this cycle
- IMEM_RDATA  in  32  instruction word, valid when IMEM_REQ&IMEM_ACK
- JUMP_EN  in  1  redirect request from EX (branch/jump/trap/mret)
- JUMP_ADDR  in  32  redirect target; bits [1:0] ignored (forced 00)
- HOLD_EN  in  1  decode/hazard stall; current IF2ID output must be held
- IF2ID_ADDR  out  32  address of presented instruction
- IF2ID_INS  out  32  presented instruction
- IF2ID_VALID  out  1  presented instruction is real (not filler)
- WASH_EN  out  1  pipeline wash pulse to decode/execute

Behaviour:
- Reset (nRST=0 at clock edge):
  - PC<=RESET_ADDR; FIFO emptied; FSM<=IDLE.
  - Outputs: IMEM_REQ=0, IF2ID_VALID=0, IF2ID_INS=NOP_INS, IF2ID_ADDR=0, WASH_EN=0.
  - Reset mid-request abandons the request; any later ACK is ignored until a new request is issued.
- Outputs:
  - FIFO empty: IF2ID_ADDR=0, IF2ID_INS=NOP_INS, IF2ID_VALID=0.
  - FIFO not empty: the head entry {addr,ins} drives IF2ID_ADDR/IF2ID_INS, and IF2ID_VALID=1.
- Pop: pop the head when IF2ID_VALID & ~HOLD_EN & ~JUMP_EN. While HOLD_EN=1, IF2ID outputs stay constant.
- Issue rule:
  - Issue a request only when count + outstanding < FIFO_DEPTH, where outstanding is 0 or 1.
  - At most one request outstanding; the FIFO therefore never overflows.
  - Push and pop in the same cycle is legal.
- FSM states:
  - IDLE: no request outstanding. IMEM_REQ = issue-rule true & ~JUMP_EN. IMEM_ADDR = PC.
    - REQ & ACK: push {PC, IMEM_RDATA}, PC<=PC+4, stay IDLE (zero-wait memory gives one fetch per cycle).
    - REQ & ~ACK: go WAIT.
  - WAIT: IMEM_REQ=1, IMEM_ADDR=PC held.
    - ACK & ~JUMP_EN: push, PC<=PC+4, go IDLE.
    - JUMP_EN & ACK: discard data, PC<=JUMP_ADDR, go IDLE.
    - JUMP_EN & ~ACK: PC<=JUMP_ADDR, go DROP.
  - DROP: IMEM_REQ=1, IMEM_ADDR = old address, so the stale request completes legally.
    - ACK: discard data, go IDLE.
    - JUMP_EN in DROP: PC<=JUMP_ADDR, remain DROP.
- Jump: when JUMP_EN=1 at an edge:
  - FIFO is flushed; the pop for that cycle is suppressed.
  - PC<=JUMP_ADDR&~3. A jump overrides any PC+4 update in the same cycle.
  - No new request is issued in the JUMP_EN cycle. The first fetch of the target is issued the cycle after.
- WASH_EN:
  - Registered; high exactly one cycle after each cycle with JUMP_EN=1.
  - Back-to-back jumps give a continuous pulse.
  - Independent of HOLD_EN.
- PC arithmetic: 32-bit, PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- HOLD_EN & JUMP_EN in the same cycle: the jump wins (flush and redirect).
- Latency: with zero-wait memory, the first IF2ID_VALID rises 2 cycles after nRST deasserts (request cycle, then data presented).

Test Plan:
- Zero-wait memory (ACK=REQ), memory returns addr-based words, release reset -> IMEM_ADDR 0,4,8… in consecutive cycles; IF2ID_ADDR/IF2ID_INS advance one per cycle from cycle 2, IF2ID_VALID=1 continuously.
- HOLD_EN=1 for 5 cycles with FIFO_DEPTH=2 -> FIFO fills (2 entries), IMEM_REQ drops to 0, IF2ID outputs frozen; after release, stream resumes with no skipped or duplicated address.
- 3-cycle-latency memory, JUMP_EN with JUMP_ADDR=32'h0000_0103 while in WAIT -> FSM enters DROP; stale ACK data never reaches IF2ID; next IMEM_ADDR=32'h0000_0100; WASH_EN high exactly the cycle after the jump.
- JUMP_EN coincident with ACK in WAIT -> data discarded, FIFO empty (IF2ID_VALID=0, IF2ID_INS=32'h0000_0013), next request at JUMP_ADDR.
- RESET_ADDR=32'hFFFF_FFF8, zero-wait -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- nRST=0 asserted while in WAIT, late ACK arrives during reset -> IMEM_REQ=0, FIFO empty, PC=RESET_ADDR; first post-reset request at RESET_ADDR.
